// File: rtl/lc3_seq_ctrl.sv
// ---------------------------------------------------------------------------
// lc3_seq_ctrl -- multi-cycle sequencer for a simple LC-3 datapath.
//
// Walks each instruction through the following stages:
//     FETCH -> DECODE -> EXECUTE -> [MEM_IND] -> [MEM_READ | MEM_WRITE]
//           -> [WRITEBACK] -> UPDATE_PC
// It raises exactly one stage enable per cycle.
//
// Every output comes straight from a flop. The next-state decode feeds those
// flops, so no input reaches an output without first crossing a clock edge.
//
// Parameter:
//     RESET_DELAY       IDLE cycles after reset release before the first
//                       FETCH (legal range 1..15)
//
// Ports:
//     clock             rising-edge clock
//     reset             asynchronous, active-high reset (forces IDLE)
//     complete_instr    instruction word is valid on IMem_dout (FETCH only)
//     complete_data     data memory access finished (memory states only)
//     IMem_dout[15:0]   fetched instruction word
//     psr[2:0]          condition codes {N,Z,P}
//     enable_fetch      fetch stage enable
//     enable_decode     decode stage enable
//     enable_execute    execute stage enable
//     enable_writeback  register writeback enable
//     enable_updatePC   PC load/increment strobe
//     br_taken          PC update takes the target (valid in UPDATE_PC only)
//     mem_state[1:0]    0 read, 1 indirect, 2 write, 3 idle
//     stall_count[15:0] saturating stall counter (optional, see below)
//
// Optional build feature:
//     LC3_SEQ_CTRL_STALL_CNT_EN  adds the stall_count output and its counter
// ---------------------------------------------------------------------------
module lc3_seq_ctrl #(
    parameter int unsigned RESET_DELAY = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        complete_instr,
    input  logic        complete_data,
    input  logic [15:0] IMem_dout,
    input  logic [2:0]  psr,
    output logic        enable_fetch,
    output logic        enable_decode,
    output logic        enable_execute,
    output logic        enable_writeback,
    output logic        enable_updatePC,
    output logic        br_taken,
    output logic [1:0]  mem_state
`ifdef LC3_SEQ_CTRL_STALL_CNT_EN
    ,
    output logic [15:0] stall_count
`endif
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_EXECUTE   = 4'd3,
        S_MEM_IND   = 4'd4,
        S_MEM_READ  = 4'd5,
        S_MEM_WRITE = 4'd6,
        S_WRITEBACK = 4'd7,
        S_UPDATE_PC = 4'd8
    } state_t;

    localparam logic [1:0] MS_READ  = 2'd0;
    localparam logic [1:0] MS_IND   = 2'd1;
    localparam logic [1:0] MS_WRITE = 2'd2;
    localparam logic [1:0] MS_IDLE  = 2'd3;

    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_LD  = 4'b0010;
    localparam logic [3:0] OP_ST  = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_NOT = 4'b1001;
    localparam logic [3:0] OP_LDI = 4'b1010;
    localparam logic [3:0] OP_STI = 4'b1011;
    localparam logic [3:0] OP_JMP = 4'b1100;
    localparam logic [3:0] OP_LEA = 4'b1110;

    localparam logic [3:0] DELAY_C = 4'(RESET_DELAY);

    // Branch decision from the instruction register and the live condition codes.
    function automatic logic br_eval(input logic [15:0] ir, input logic [2:0] cc);
        logic taken;
        case (ir[15:12])
            OP_BR:   taken = |(ir[11:9] & cc);
            OP_JMP:  taken = 1'b1;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

    // Registered state, counters and outputs
    state_t      state_q, state_d;
    logic [3:0]  dly_q, dly_d;
    logic [15:0] ir_q, ir_d;
    logic        br_next_q, br_next_d;
    logic        en_fetch_q, en_fetch_d;
    logic        en_decode_q, en_decode_d;
    logic        en_execute_q, en_execute_d;
    logic        en_wb_q, en_wb_d;
    logic        en_upc_q, en_upc_d;
    logic        br_taken_q, br_taken_d;
    logic [1:0]  mem_state_q, mem_state_d;

    // Operand fields of the IR belong to the datapath; the sequencer only
    // looks at the opcode and the branch condition mask.
    logic        ir_unused_s;
    assign ir_unused_s = ^ir_q[8:0];

    // Next-state decode: sequencing, IR capture and branch decision latch.
    always_comb begin
        state_d   = state_q;
        dly_d     = dly_q;
        ir_d      = ir_q;
        br_next_d = br_next_q;
        case (state_q)
            S_IDLE: begin
                if (dly_q >= DELAY_C) begin
                    state_d = S_FETCH;
                end else begin
                    dly_d = dly_q + 4'd1;
                end
            end
            S_FETCH: begin
                if (complete_instr) begin
                    ir_d    = IMem_dout;
                    state_d = S_DECODE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                state_d = S_EXECUTE;
            end
            S_EXECUTE: begin
                // psr is sampled here, on the edge that leaves EXECUTE.
                br_next_d = br_eval(ir_q, psr);
                case (ir_q[15:12])
                    OP_ADD, OP_AND, OP_NOT, OP_LEA: state_d = S_WRITEBACK;
                    OP_LD, OP_LDR:                  state_d = S_MEM_READ;
                    OP_LDI, OP_STI:                 state_d = S_MEM_IND;
                    OP_ST, OP_STR:                  state_d = S_MEM_WRITE;
                    default:                        state_d = S_UPDATE_PC;
                endcase
            end
            S_MEM_IND: begin
                // IR[12] splits LDI (1010) from STI (1011).
                if (complete_data) begin
                    state_d = ir_q[12] ? S_MEM_WRITE : S_MEM_READ;
                end else begin
                    state_d = S_MEM_IND;
                end
            end
            S_MEM_READ: begin
                if (complete_data) begin
                    state_d = S_WRITEBACK;
                end else begin
                    state_d = S_MEM_READ;
                end
            end
            S_MEM_WRITE: begin
                if (complete_data) begin
                    state_d = S_UPDATE_PC;
                end else begin
                    state_d = S_MEM_WRITE;
                end
            end
            S_WRITEBACK: begin
                state_d = S_UPDATE_PC;
            end
            S_UPDATE_PC: begin
                state_d = S_FETCH;
            end
            default: begin
                state_d = S_IDLE;
                dly_d   = 4'd0;
            end
        endcase
    end

    // Output decode from the next state so outputs can be registered and
    // still line up with the state they describe.
    always_comb begin
        en_fetch_d   = 1'b0;
        en_decode_d  = 1'b0;
        en_execute_d = 1'b0;
        en_wb_d      = 1'b0;
        en_upc_d     = 1'b0;
        br_taken_d   = 1'b0;
        mem_state_d  = MS_IDLE;
        case (state_d)
            S_FETCH:     en_fetch_d   = 1'b1;
            S_DECODE:    en_decode_d  = 1'b1;
            S_EXECUTE:   en_execute_d = 1'b1;
            S_MEM_IND:   mem_state_d  = MS_IND;
            S_MEM_READ:  mem_state_d  = MS_READ;
            S_MEM_WRITE: mem_state_d  = MS_WRITE;
            S_WRITEBACK: en_wb_d      = 1'b1;
            S_UPDATE_PC: begin
                en_upc_d   = 1'b1;
                br_taken_d = br_next_d;
            end
            default: begin
                mem_state_d = MS_IDLE;
            end
        endcase
    end

`ifdef LC3_SEQ_CTRL_STALL_CNT_EN
    logic [15:0] stall_q, stall_d;
    logic        stall_evt_s;

    // A stall is a cycle spent waiting on memory in FETCH or a memory state.
    always_comb begin
        stall_evt_s = 1'b0;
        case (state_q)
            S_FETCH:                           stall_evt_s = ~complete_instr;
            S_MEM_IND, S_MEM_READ, S_MEM_WRITE: stall_evt_s = ~complete_data;
            default:                           stall_evt_s = 1'b0;
        endcase
        if (stall_evt_s && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end else begin
            stall_d = stall_q;
        end
    end

    // Stall counter register, cleared only by reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_q <= 16'd0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_count = stall_q;
`endif

    // FSM state, IR and registered outputs; reset abandons any instruction.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            dly_q        <= 4'd0;
            ir_q         <= 16'd0;
            br_next_q    <= 1'b0;
            en_fetch_q   <= 1'b0;
            en_decode_q  <= 1'b0;
            en_execute_q <= 1'b0;
            en_wb_q      <= 1'b0;
            en_upc_q     <= 1'b0;
            br_taken_q   <= 1'b0;
            mem_state_q  <= MS_IDLE;
        end else begin
            state_q      <= state_d;
            dly_q        <= dly_d;
            ir_q         <= ir_d;
            br_next_q    <= br_next_d;
            en_fetch_q   <= en_fetch_d;
            en_decode_q  <= en_decode_d;
            en_execute_q <= en_execute_d;
            en_wb_q      <= en_wb_d;
            en_upc_q     <= en_upc_d;
            br_taken_q   <= br_taken_d;
            mem_state_q  <= mem_state_d;
        end
    end

    assign enable_fetch     = en_fetch_q;
    assign enable_decode    = en_decode_q;
    assign enable_execute   = en_execute_q;
    assign enable_writeback = en_wb_q;
    assign enable_updatePC  = en_upc_q;
    assign br_taken         = br_taken_q;
    assign mem_state        = mem_state_q;

endmodule

// File: tb/tb_lc3_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lc3_seq_ctrl -- scoreboard bench for lc3_seq_ctrl (RESET_DELAY = 3).
//
// The stimulus side queues the per-cycle output vector that each instruction
// must produce after its FETCH. These vectors are computed by hand from the
// opcode and the memory wait lengths. A monitor logs every non-idle,
// non-fetch cycle and pops the queue to compare against it.
//
// Vector layout: {fetch, decode, execute, writeback, updatePC, br_taken,
// mem_state[1:0]}.
// ---------------------------------------------------------------------------
module tb_lc3_seq_ctrl;

    logic        clock;
    logic        reset;
    logic        complete_instr;
    logic        complete_data;
    logic [15:0] IMem_dout;
    logic [2:0]  psr;
    logic        enable_fetch;
    logic        enable_decode;
    logic        enable_execute;
    logic        enable_writeback;
    logic        enable_updatePC;
    logic        br_taken;
    logic [1:0]  mem_state;
`ifdef LC3_SEQ_CTRL_STALL_CNT_EN
    logic [15:0] stall_count;
`endif

    lc3_seq_ctrl #(.RESET_DELAY(3)) dut (
        .clock            (clock),
        .reset            (reset),
        .complete_instr   (complete_instr),
        .complete_data    (complete_data),
        .IMem_dout        (IMem_dout),
        .psr              (psr),
        .enable_fetch     (enable_fetch),
        .enable_decode    (enable_decode),
        .enable_execute   (enable_execute),
        .enable_writeback (enable_writeback),
        .enable_updatePC  (enable_updatePC),
        .br_taken         (br_taken),
        .mem_state        (mem_state)
`ifdef LC3_SEQ_CTRL_STALL_CNT_EN
        ,
        .stall_count      (stall_count)
`endif
    );

    localparam logic [7:0] V_IDLE = 8'b0000_0011;
    localparam logic [7:0] V_DEC  = 8'b0100_0011;
    localparam logic [7:0] V_EXE  = 8'b0010_0011;
    localparam logic [7:0] V_WB   = 8'b0001_0011;
    localparam logic [7:0] V_UPC0 = 8'b0000_1011;
    localparam logic [7:0] V_UPC1 = 8'b0000_1111;
    localparam logic [7:0] V_MIND = 8'b0000_0001;
    localparam logic [7:0] V_MRD  = 8'b0000_0000;
    localparam logic [7:0] V_MWR  = 8'b0000_0010;

    logic [7:0] obs_s;
    assign obs_s = {enable_fetch, enable_decode, enable_execute, enable_writeback,
                    enable_updatePC, br_taken, mem_state};

    int         n_cmp  = 0;
    int         n_fail = 0;
    int         cyc    = 0;
    logic [7:0] exp_q[$];
    int         fetch_times[$];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: log fetch entries, and score every other active cycle.
    initial begin
        logic prev_fetch;
        logic [7:0] e;
        prev_fetch = 1'b0;
        forever begin
            @(negedge clock);
            cyc = cyc + 1;
            if (!reset) begin
                if (enable_fetch && !prev_fetch) fetch_times.push_back(cyc);
                if ((obs_s & 8'h7F) != V_IDLE) begin
                    if (exp_q.size() == 0) begin
                        n_cmp  = n_cmp + 1;
                        n_fail = n_fail + 1;
                        $display("FAIL sb_unexpected: got %b, expected nothing at cycle %0d", obs_s, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        chk("sb_vector", int'(obs_s), int'(e));
                    end
                end
            end
            prev_fetch = enable_fetch;
        end
    end

    // Issue one instruction; queue its hand-computed output sequence first.
    task automatic run_instr(input logic [15:0] instr, input logic [2:0] cc, input int d,
                             input bit stray, input int n_ind, input int n_rd,
                             input int n_wr, input bit wb, input bit br);
        int  k;
        int  cnt;
        logic [1:0] ph;
        bit  done;
        logic cd;
        exp_q.push_back(V_DEC);
        exp_q.push_back(V_EXE);
        for (int i = 0; i < n_ind; i++) exp_q.push_back(V_MIND);
        for (int i = 0; i < n_rd; i++)  exp_q.push_back(V_MRD);
        for (int i = 0; i < n_wr; i++)  exp_q.push_back(V_MWR);
        if (wb) exp_q.push_back(V_WB);
        exp_q.push_back(br ? V_UPC1 : V_UPC0);

        k = 0;
        while (!enable_fetch && k < 50) begin
            @(negedge clock);
            k = k + 1;
        end
        if (!enable_fetch) chk("fetch_timeout", 0, 1);
        IMem_dout      = instr;
        psr            = cc;
        complete_instr = 1'b1;
        @(negedge clock);
        complete_instr = 1'b0;
        IMem_dout      = 16'hFFFF;

        ph = 2'd3; cnt = 0; done = 1'b0; k = 0;
        while (!done && k < 100) begin
            cd = 1'b0;
            if (stray && enable_decode) cd = 1'b1;
            if (mem_state != 2'd3) begin
                if (mem_state != ph) begin
                    ph  = mem_state;
                    cnt = 0;
                end else begin
                    cnt = cnt + 1;
                end
                cd = (cnt == d);
            end else begin
                ph = 2'd3;
            end
            complete_data  = cd;
            complete_instr = stray && enable_decode;
            if (enable_updatePC) begin
                done = 1'b1;
            end else begin
                @(negedge clock);
                k = k + 1;
            end
        end
        complete_data  = 1'b0;
        complete_instr = 1'b0;
        if (!done) chk("instr_timeout", 0, 1);
    endtask

    // Count rising edges from reset release (at a negedge) to enable_fetch.
    task automatic release_and_count(input string name);
        int e;
        e = 0;
        reset = 1'b0;
        while (!enable_fetch && e < 20) begin
            @(posedge clock);
            e = e + 1;
            @(negedge clock);
        end
        chk(name, e, 4);
    endtask

    initial begin
        int seen;
        reset = 1'b1; complete_instr = 1'b0; complete_data = 1'b0;
        IMem_dout = 16'h0000; psr = 3'b000;
        #2;
        chk("reset_async_initial", int'(obs_s), int'(V_IDLE));
        repeat (3) @(negedge clock);
        release_and_count("reset_delay_edges");

        // ALU, then branches (taken / not taken / all-cc / never)
        run_instr(16'h1042, 3'b000, 0, 1'b0, 0, 0, 0, 1'b1, 1'b0);
        run_instr(16'h0405, 3'b010, 0, 1'b0, 0, 0, 0, 1'b0, 1'b1);
        run_instr(16'h0405, 3'b100, 0, 1'b0, 0, 0, 0, 1'b0, 1'b0);
        chk("latency_alu", fetch_times[1] - fetch_times[0], 5);
        chk("latency_br", fetch_times[2] - fetch_times[1], 4);
        run_instr(16'h0E00, 3'b001, 0, 1'b0, 0, 0, 0, 1'b0, 1'b1);
        run_instr(16'h0000, 3'b111, 0, 1'b0, 0, 0, 0, 1'b0, 1'b0);
`ifdef LC3_SEQ_CTRL_STALL_CNT_EN
        chk("stall_before_ldi", int'(stall_count), 0);
`endif
        // LDI with three wait cycles on each memory phase
        run_instr(16'hA201, 3'b000, 3, 1'b0, 4, 4, 0, 1'b1, 1'b0);
`ifdef LC3_SEQ_CTRL_STALL_CNT_EN
        chk("stall_after_ldi", int'(stall_count), 6);
`endif
        run_instr(16'hB201, 3'b000, 1, 1'b0, 2, 0, 2, 1'b0, 1'b0);
        run_instr(16'hC1C0, 3'b000, 0, 1'b0, 0, 0, 0, 1'b0, 1'b1);
        // reserved opcode with stray handshakes during DECODE
        run_instr(16'hD000, 3'b111, 0, 1'b1, 0, 0, 0, 1'b0, 1'b0);
        run_instr(16'h2000, 3'b000, 0, 1'b0, 0, 1, 0, 1'b1, 1'b0);
        run_instr(16'h3000, 3'b000, 2, 1'b0, 0, 0, 3, 1'b0, 1'b0);
        run_instr(16'h5000, 3'b010, 0, 1'b1, 0, 0, 0, 1'b1, 1'b0);

        // Reset while MEM_READ waits on complete_data
        exp_q.push_back(V_DEC);
        exp_q.push_back(V_EXE);
        exp_q.push_back(V_MRD);
        exp_q.push_back(V_MRD);
        seen = 0;
        while (!enable_fetch && seen < 50) begin
            @(negedge clock);
            seen = seen + 1;
        end
        IMem_dout = 16'h6000; complete_instr = 1'b1;
        @(negedge clock);
        complete_instr = 1'b0;
        seen = 0;
        for (int k = 0; k < 20 && seen < 2; k++) begin
            if (mem_state == 2'd0) seen = seen + 1;
            if (seen < 2) @(negedge clock);
        end
        chk("mem_read_reached", seen, 2);
        #1 reset = 1'b1;
        #1;
        chk("reset_async_midinstr", int'(obs_s), int'(V_IDLE));
        repeat (2) @(negedge clock);
        release_and_count("reset_delay_edges_2");
        repeat (5) @(negedge clock);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
